lsu_rmw: RTL
============

// Module: lsu_rmw
// PURPOSE
//  Load/store initiator for the word-only data memory (comb read, sync word write, no byte enables).
//  Accepts byte/half/word loads and stores from the CPU memory stage with a valid/ready request.
//  Services sub-word stores by read-modify-write of the containing word.
//  Returns extracted/extended load data.
//  Flags misaligned, out-of-range or reserved-size requests without touching memory.
// PARAMETERS
//  MEM_WORDS    64  words in data memory; word index addr[31:2] >= MEM_WORDS is out of range
//  CHECK_RANGE  1   1: out-of-range access -> error; 0: no range check
// PORTS
//  clk           in   1   clock, all state on posedge
//  reset         in   1   asynchronous, active-high
//  req_valid     in   1   request present
//  req_ready     out  1   unit idle, request accepted when valid&&ready at posedge
//  req_we        in   1   1 store, 0 load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1   zero-extend sub-word loads (else sign-extend)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  resp_valid    out  1   one-cycle completion pulse
//  resp_rdata    out  32  load result, valid with resp_valid (0 for stores/errors)
//  resp_err      out  1   valid with resp_valid: misaligned/out-of-range/reserved size
//  mem_a         out  32  word address to dmem, bits [1:0] always 0
//  mem_wd        out  32  write data to dmem
//  mem_we        out  1   dmem write enable
//  mem_rd        in   32  dmem read data, combinational from mem_a
// BEHAVIOUR
//  Reset (async): state IDLE; all latched regs 0.
//   Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_a=0, mem_wd=0, mem_we=0.
//  FSM states: IDLE, LOAD, READ, WRITE, DONE. req_ready=1 only in IDLE; requests while busy are ignored.
//  IDLE: on accept, latch we/size/unsigned/addr/wdata and compute err; next state:
//   err -> DONE; load -> LOAD; word store -> WRITE; byte/half store -> READ.
//  Error conditions:
//   - size 11
//   - half with addr[0]=1
//   - word with addr[1:0]!=0
//   - CHECK_RANGE && addr[31:2] >= MEM_WORDS
//  LOAD: mem_a={addr[31:2],2'b00}; register extracted mem_rd into resp_rdata; -> DONE.
//  READ: same mem_a; register merged word (mem_rd with target lanes replaced by wdata) -> WRITE.
//  WRITE: mem_we=1, mem_wd = merged word (sub-word) or wdata (word); -> DONE.
//  DONE: resp_valid=1, resp_err as latched; -> IDLE (req_ready high next cycle).
//  mem_we is 1 only in WRITE. mem_a/mem_wd hold last value outside LOAD/READ/WRITE.
//  Latency, accept edge T to resp_valid:
//   error T+1; load T+2; word store T+2; sub-word store T+3.
//   Throughput: one request per latency+1 cycles.
//  Lanes, little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; half h = bits [16h+15:16h], h=addr[1].
//  Extension: sub-word load sign-extends from MSB of lane unless req_unsigned; word load ignores req_unsigned.
//  Store data: byte uses wdata[7:0], half uses wdata[15:0]; upper bits ignored.
//  Reset mid-operation: abort immediately, mem_we drops asynchronously, no write issued, no resp_valid.
//  Requester may change req_* after accept; the unit uses only latched copies.
// STRUCTURE
//  mem_pkg:
//   - size_t enum (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11)
//   - lsu_state_t enum
//   - function is_misaligned(size, addr[1:0])
//  Sub-module byte_lane_unit (combinational): inputs word, addr[1:0], size, unsigned, wdata;
//   outputs load_ext and store_merged. Instantiated once in lsu_rmw; FSM and registers stay in lsu_rmw.
// TESTING
//  1. Reset asserted mid-WRITE:
//     mem_we falls same cycle, memory unchanged, req_ready=1 after release, resp_valid never pulses.
//  2. Word store 0xDEADBEEF @0x10, then word load @0x10:
//     mem_we once at T+1, resp_valid at T+2; load resp_rdata=0xDEADBEEF, resp_err=0.
//  3. Word 0x11223344 @0x20; sb 0xAA @0x21:
//     READ then WRITE, mem_wd=0x1122AA44, resp at T+3; lb @0x21 -> 0xFFFFFFAA, lbu -> 0x000000AA.
//  4. sh 0x8001 @0x22 over 0x11223344:
//     word becomes 0x80013344; lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001.
//  5. lw @0x06, sh @0x03, size 11, and (MEM_WORDS=64) lw @0x100:
//     resp_err=1 at T+1, resp_rdata=0, mem_we never asserted.
//  6. Back-to-back req_valid held high with changing req_addr:
//     only IDLE-cycle values accepted, each completes in order, no request dropped or duplicated.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store read-modify-write unit.
// Sizes follow the CPU memory-stage encoding; states cover the complete request lifecycle.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_t;

  // Reserved size is reported separately, so it is not treated as misaligned here.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Request and response bundle between the CPU memory stage and the load/store unit.
// The master drives requests. The slave returns the handshake ready signal and the responses.
interface lsu_rmw_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_rmw_byte_lane_unit.sv
// Combinational lane logic: extracts and extends load data, and merges sub-word store data.
// Lanes are little-endian within the containing word.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  size_t       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and the addressed halfword from the memory word
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected lane to 32 bits
  always_comb begin
    load_ext = 32'h0000_0000;
    case (size)
      SZ_BYTE: load_ext = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_HALF: load_ext = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      SZ_WORD: load_ext = word;
      default: load_ext = 32'h0000_0000;
    endcase
  end

  // Overwrite only the target lanes; upper store-data bits are ignored
  always_comb begin
    store_merged = word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    store_merged[7:0]   = wdata[7:0];
          2'd1:    store_merged[15:8]  = wdata[7:0];
          2'd2:    store_merged[23:16] = wdata[7:0];
          2'd3:    store_merged[31:24] = wdata[7:0];
          default: store_merged = word;
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) begin
          store_merged[31:16] = wdata[15:0];
        end else begin
          store_merged[15:0] = wdata[15:0];
        end
      end
      SZ_WORD: store_merged = wdata;
      default: store_merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator for a word-only data memory. Sub-word stores are done as read-modify-write.
// Illegal requests complete with an error and do not access memory.
module lsu_rmw
  import mem_pkg::*;
#(
  parameter int MEM_WORDS   = 64,
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        reset,
  lsu_rmw_if.slave    bus,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state_r, state_s;
  size_t       size_r;
  logic        uns_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] mem_a_r;
  logic [31:0] mem_wd_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;

  size_t       req_size_s;
  logic        accept_s;
  logic        err_s;
  logic [31:0] widx_s;
  logic [31:0] load_ext_s;
  logic [31:0] store_merged_s;

  assign req_size_s = size_t'(bus.req_size);
  assign accept_s   = (state_r == ST_IDLE) && bus.req_valid;
  assign widx_s     = {2'b00, bus.req_addr[31:2]};

  // Classify the incoming request as legal or illegal
  always_comb begin
    err_s = 1'b0;
    if (req_size_s == SZ_RSVD) begin
      err_s = 1'b1;
    end else if (is_misaligned(req_size_s, bus.req_addr[1:0])) begin
      err_s = 1'b1;
    end else if ((CHECK_RANGE != 0) && (widx_s >= 32'(MEM_WORDS))) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  byte_lane_unit u_lanes (
    .word         (mem_rd),
    .addr_lo      (addr_r[1:0]),
    .size         (size_r),
    .is_unsigned  (uns_r),
    .wdata        (wdata_r),
    .load_ext     (load_ext_s),
    .store_merged (store_merged_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; loads and stores share the same exit through DONE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.req_valid) begin
          state_s = ST_IDLE;
        end else if (err_s) begin
          state_s = ST_DONE;
        end else if (!bus.req_we) begin
          state_s = ST_LOAD;
        end else if (req_size_s == SZ_WORD) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_LOAD:  state_s = ST_DONE;
      ST_READ:  state_s = ST_WRITE;
      ST_WRITE: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Datapath registers. mem_a/mem_wd are loaded before the cycle that uses them, then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_r       <= SZ_BYTE;
      uns_r        <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      mem_a_r      <= 32'h0000_0000;
      mem_wd_r     <= 32'h0000_0000;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            size_r       <= req_size_s;
            uns_r        <= bus.req_unsigned;
            addr_r       <= bus.req_addr;
            wdata_r      <= bus.req_wdata;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= err_s;
            if (!err_s) begin
              mem_a_r <= {bus.req_addr[31:2], 2'b00};
            end
            if (!err_s && bus.req_we && (req_size_s == SZ_WORD)) begin
              mem_wd_r <= bus.req_wdata;
            end
          end
        end
        ST_LOAD:  resp_rdata_r <= load_ext_s;
        ST_READ:  mem_wd_r     <= store_merged_s;
        default:  resp_err_r   <= resp_err_r;
      endcase
    end
  end

  // mem_we is decoded from the state register, so an asynchronous reset removes it immediately
  assign mem_we         = (state_r == ST_WRITE);
  assign mem_a          = mem_a_r;
  assign mem_wd         = mem_wd_r;
  assign bus.req_ready  = (state_r == ST_IDLE);
  assign bus.resp_valid = (state_r == ST_DONE);
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule
